// File: rtl/partial_load_unit_if.sv
// Bundle of the load request, data-memory read port and writeback response
// handshakes that connect the partial load unit to its neighbours.
interface partial_load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  logic [31:0] req_addr;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  // Load unit side.
  modport slave (
    input  req_valid, req_inst, req_addr, mem_rdata, resp_ready,
    output req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err
  );

  // Pipeline/memory side.
  modport master (
    output req_valid, req_inst, req_addr, mem_rdata, resp_ready,
    input  req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/partial_load_unit.sv
// Load unit: word reads from a synchronous-read data memory, splitting
// word-crossing loads into two reads, then extracting and extending per funct3.
module partial_load_unit #(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  partial_load_unit_if.slave bus
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [2:0] FNC_LB   = 3'b000;
  localparam logic [2:0] FNC_LH   = 3'b001;
  localparam logic [2:0] FNC_LW   = 3'b010;
  localparam logic [2:0] FNC_LBU  = 3'b100;
  localparam logic [2:0] FNC_LHU  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        req_ready;
  logic        accept;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        unused_inst;

  function automatic logic legal_load(input logic [31:0] inst);
    logic ok;
    ok = 1'b0;
    if (inst[6:0] == OPC_LOAD) begin
      case (inst[14:12])
        FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU: ok = 1'b1;
        default:                                  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    logic c;
    case (f3)
      FNC_LW:         c = (off != 2'd0);
      FNC_LH, FNC_LHU: c = (off == 2'd3);
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

  // dw is {word1, word0}; the byte offset selects a 32-bit window before extension.
  function automatic logic [31:0] extract(input logic [63:0] dw, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] r;
    sh = dw[{off, 3'b000} +: 32];
    case (f3)
      FNC_LB:  r = {{24{sh[7]}}, sh[7:0]};
      FNC_LH:  r = {{16{sh[15]}}, sh[15:0]};
      FNC_LW:  r = sh;
      FNC_LBU: r = {24'd0, sh[7:0]};
      FNC_LHU: r = {16'd0, sh[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    waddr_d     = waddr_q;
    offset_d    = offset_q;
    word0_d     = word0_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_en      = 1'b0;
    mem_addr    = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = bus.req_inst[14:12];
          waddr_d  = bus.req_addr[31:2];
          offset_d = bus.req_addr[1:0];
          if (legal_load(bus.req_inst)) begin
            mem_en   = 1'b1;
            mem_addr = {bus.req_addr[31:2], 2'b00};
            state_d  = RD0;
          end else begin
            resp_data_d = 32'd0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end
        end
      end

      RD0: begin
        word0_d = bus.mem_rdata;
        if (crosses(funct3_q, offset_q)) begin
          if (ALLOW_SPLIT) begin
            // 30-bit word address increment wraps 0xFFFFFFFC to 0x00000000.
            mem_en   = 1'b1;
            mem_addr = {waddr_q + 30'd1, 2'b00};
            state_d  = RD1;
          end else begin
            resp_data_d = 32'd0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end
        end else begin
          resp_data_d = extract({32'd0, bus.mem_rdata}, offset_q, funct3_q);
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end
      end

      RD1: begin
        resp_data_d = extract({bus.mem_rdata, word0_q}, offset_q, funct3_q);
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= 3'd0;
      waddr_q     <= 30'd0;
      offset_q    <= 2'd0;
      word0_q     <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      waddr_q     <= waddr_d;
      offset_q    <= offset_d;
      word0_q     <= word0_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mem_en     = mem_en;
  assign bus.mem_addr   = mem_addr;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  // Only opcode and funct3 of the instruction matter here.
  assign unused_inst = ^{bus.req_inst[31:15], bus.req_inst[11:7]};

endmodule

// File: tb/tb_partial_load_unit.sv
// Directed bench for partial_load_unit: one split-enabled and one split-disabled
// instance share the request stream; a per-instance scoreboard checks responses.
module tb_partial_load_unit;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;   // cycles from accept to response handshake, <0 = not checked
    int          nrd;
    logic [31:0] a0;
    logic [31:0] a1;
  } exp_t;

  logic        clk;
  logic        rst_a, rst_b;
  logic        req_valid;
  logic [31:0] req_inst, req_addr;
  logic        resp_ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t qa[$];
  exp_t qb[$];
  int          acc [2];
  int          nrd [2];
  int          c0  [2];
  int          c1  [2];
  logic [31:0] ra0 [2];
  logic [31:0] ra1 [2];

  partial_load_unit_if bus_a();
  partial_load_unit_if bus_b();

  assign bus_a.req_valid  = req_valid;
  assign bus_a.req_inst   = req_inst;
  assign bus_a.req_addr   = req_addr;
  assign bus_a.resp_ready = resp_ready;
  assign bus_b.req_valid  = req_valid;
  assign bus_b.req_inst   = req_inst;
  assign bus_b.req_addr   = req_addr;
  assign bus_b.resp_ready = resp_ready;

  partial_load_unit #(.ALLOW_SPLIT(1'b1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
  partial_load_unit #(.ALLOW_SPLIT(1'b0)) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8899AABB;
      32'h0000_0104: return 32'h11223344;
      32'hFFFF_FFFC: return 32'hCAFEF00D;
      32'h0000_0000: return 32'h01234567;
      default:       return 32'hDEADBEEF;
    endcase
  endfunction

  // Synchronous-read memories; data is garbage except the cycle after a read.
  always @(posedge clk) begin
    if (bus_a.mem_en) bus_a.mem_rdata <= mem_word(bus_a.mem_addr);
    else              bus_a.mem_rdata <= 32'h5A5A_5A5A;
    if (bus_b.mem_en) bus_b.mem_rdata <= mem_word(bus_b.mem_addr);
    else              bus_b.mem_rdata <= 32'hA5A5_A5A5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic e, input int lat,
                              input int n, input logic [31:0] a0, input logic [31:0] a1);
    exp_t r;
    r.data = d; r.err = e; r.lat = lat; r.nrd = n; r.a0 = a0; r.a1 = a1;
    return r;
  endfunction

  function automatic logic [31:0] ld(input logic [2:0] f3);
    logic [31:0] i;
    i = {17'd0, f3, 5'd0, 7'b0000011};
    return i;
  endfunction

  task automatic mon(input int id, input logic rst, input logic rv, input logic rr,
                     input logic [31:0] rd, input logic re, input logic me,
                     input logic [31:0] ma, input logic qv, input logic qr);
    exp_t  e;
    bit    have;
    string p;
    p = (id == 0) ? "A" : "B";
    if (!rst) begin
      nrd[id] = 0;
      return;
    end
    if (qv && qr) begin
      acc[id] = cyc;
      nrd[id] = 0;
    end
    if (me) begin
      if (nrd[id] == 0) begin ra0[id] = ma; c0[id] = cyc - acc[id]; end
      else if (nrd[id] == 1) begin ra1[id] = ma; c1[id] = cyc - acc[id]; end
      nrd[id]++;
    end
    if (rv && rr) begin
      have = 1'b0;
      if (id == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      if (id == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      chk({p, ".resp_expected"}, 32'(have), 32'd1);
      if (have) begin
        chk({p, ".resp_data"}, rd, e.data);
        chk({p, ".resp_err"}, 32'(re), 32'(e.err));
        if (e.lat >= 0) chk({p, ".latency"}, 32'(cyc - acc[id]), 32'(e.lat));
        chk({p, ".num_reads"}, 32'(nrd[id]), 32'(e.nrd));
        if (e.nrd > 0) begin
          chk({p, ".rd0_addr"}, ra0[id], e.a0);
          chk({p, ".rd0_cycle"}, 32'(c0[id]), 32'd0);
        end
        if (e.nrd > 1) begin
          chk({p, ".rd1_addr"}, ra1[id], e.a1);
          chk({p, ".rd1_cycle"}, 32'(c1[id]), 32'd1);
        end
        $display("[TB] %s resp data=%h err=%0d", p, rd, re);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, rst_a, bus_a.resp_valid, resp_ready, bus_a.resp_data, bus_a.resp_err,
        bus_a.mem_en, bus_a.mem_addr, req_valid, bus_a.req_ready);
  always @(negedge clk)
    mon(1, rst_b, bus_b.resp_valid, resp_ready, bus_b.resp_data, bus_b.resp_err,
        bus_b.mem_en, bus_b.mem_addr, req_valid, bus_b.req_ready);

  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input exp_t ea, input exp_t eb, input bit push_a);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!(bus_a.req_ready && bus_b.req_ready) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(bus_a.req_ready && bus_b.req_ready), 32'd1);
    $display("[TB] issue inst=%h addr=%h", inst, addr);
    req_valid = 1'b1;
    req_inst  = inst;
    req_addr  = addr;
    if (push_a) qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_timeout", 32'(qa.size() == 0 && qb.size() == 0), 32'd1);
    qa.delete();
    qb.delete();
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr,
                      input exp_t ea, input exp_t eb);
    issue(ld(f3), addr, ea, eb, 1'b1);
    wait_done();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".resp_valid"}, 32'(bus_a.resp_valid), 32'd0);
    chk({tag, ".resp_data"},  bus_a.resp_data,       32'd0);
    chk({tag, ".resp_err"},   32'(bus_a.resp_err),   32'd0);
    chk({tag, ".mem_en"},     32'(bus_a.mem_en),     32'd0);
    chk({tag, ".mem_addr"},   bus_a.mem_addr,        32'd0);
    chk({tag, ".req_ready"},  32'(bus_a.req_ready),  32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_a = 1'b0; rst_b = 1'b0;
    req_valid = 1'b0; req_inst = 32'd0; req_addr = 32'd0;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk_reset_a("reset");
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("A.req_ready_after_reset", 32'(bus_a.req_ready), 32'd1);
    chk("B.req_ready_after_reset", 32'(bus_b.req_ready), 32'd1);

    // Aligned loads
    e = mk(32'hFFFFFF88, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b000, 32'h103, e, e);
    e = mk(32'h00000088, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b100, 32'h103, e, e);
    e = mk(32'hFFFF8899, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b001, 32'h102, e, e);
    e = mk(32'h000099AA, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b101, 32'h101, e, e);
    e = mk(32'h8899AABB, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b010, 32'h100, e, e);

    // Crossing loads: split on A, error on B
    load(3'b010, 32'h102, mk(32'h33448899, 1'b0, 3, 2, 32'h100, 32'h104),
                          mk(32'h0, 1'b1, 2, 1, 32'h100, 32'h0));
    load(3'b010, 32'h101, mk(32'h448899AA, 1'b0, 3, 2, 32'h100, 32'h104),
                          mk(32'h0, 1'b1, 2, 1, 32'h100, 32'h0));
    load(3'b001, 32'h103, mk(32'h00004488, 1'b0, 3, 2, 32'h100, 32'h104),
                          mk(32'h0, 1'b1, 2, 1, 32'h100, 32'h0));
    load(3'b010, 32'hFFFFFFFE, mk(32'h4567CAFE, 1'b0, 3, 2, 32'hFFFFFFFC, 32'h0),
                               mk(32'h0, 1'b1, 2, 1, 32'hFFFFFFFC, 32'h0));

    // Store opcode and illegal funct3: immediate error, no read
    e = mk(32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    issue({17'd0, 3'b010, 5'd0, 7'b0100011}, 32'h100, e, e, 1'b1);
    wait_done();
    load(3'b011, 32'h100, e, e);

    // Consumer stalls for 5 cycles in RESP
    resp_ready = 1'b0;
    e = mk(32'h8899AABB, 1'b0, -1, 1, 32'h100, 32'h0);
    issue(ld(3'b010), 32'h100, e, e, 1'b1);
    n = 0;
    while (!bus_a.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall.resp_valid_seen", 32'(bus_a.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.resp_valid", 32'(bus_a.resp_valid), 32'd1);
      chk("stall.resp_data", bus_a.resp_data, 32'h8899AABB);
      chk("stall.req_ready", 32'(bus_a.req_ready), 32'd0);
      chk("stall.mem_en", 32'(bus_a.mem_en), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_done();

    // Reset A while in RD1; B completes its error response normally
    issue(ld(3'b010), 32'h102, e, mk(32'h0, 1'b1, 2, 1, 32'h100, 32'h0), 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk_reset_a("midreset");
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("midreset.req_ready_release", 32'(bus_a.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("midreset.no_resp", 32'(bus_a.resp_valid), 32'd0);
      @(negedge clk);
    end
    wait_done();

    // Recovery after mid-operation reset
    e = mk(32'h000000BB, 1'b0, 2, 1, 32'h100, 32'h0); load(3'b100, 32'h100, e, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/partial_load_unit.md
# partial_load_unit

Load-side memory interface for the RISC-V core; it pairs with the store mask/shift logic. It accepts a load instruction and byte address over a valid/ready handshake and issues word reads to a synchronous-read data memory. It splits word-crossing accesses into two reads, then extracts, shifts and sign- or zero-extends the result per funct3. The aligned 32-bit result is returned over a second valid/ready handshake to the writeback stage.

## Interface
- `ALLOW_SPLIT`, default 1: 1 = loads crossing a word boundary take two reads; 0 = such loads are flagged as errors.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept a request.
- `req_inst` in 32: instruction. Opcode is `inst[6:0]`; funct3 is `inst[14:12]` (`OPC_LOAD`, `FNC_LB/LH/LW/LBU/LHU` from opcode.vh).
- `req_addr` in 32: byte address.
- `mem_en` out 1: read strobe to data memory.
- `mem_addr` out 32: word-aligned read address; bits [1:0] are always 0.
- `mem_rdata` in 32: read data, valid the cycle after `mem_en` is sampled high.
- `resp_valid` out 1: result valid.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 32: extended load result.
- `resp_err` out 1: non-load opcode, illegal funct3, or a crossing load with `ALLOW_SPLIT=0`.

## Operation
- **States:** IDLE, RD0, RD1, RESP.
- **Request acceptance:**
  - `req_ready` = (state==IDLE) && `rst_n`.
  - A request is accepted when `req_valid && req_ready`.
  - On acceptance, inst, addr and offset = addr[1:0] are latched.
- **IDLE, on accept:**
  - Valid load: `mem_en`=1 in the same cycle, `mem_addr`={req_addr[31:2],2'b00}, next state RD0.
  - Non-load or illegal funct3: no read, next state RESP with `resp_data`=0 and `resp_err`=1.
- **Crossing rule:**
  - LW crosses when offset≠0.
  - LH/LHU cross when offset==3.
  - LB/LBU never cross.
- **RD0:**
  - Capture word0 from `mem_rdata`.
  - If crossing and `ALLOW_SPLIT`=1: `mem_en`=1, `mem_addr`=word0_addr+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), next state RD1.
  - If crossing and `ALLOW_SPLIT`=0: result 0, `resp_err`=1, next state RESP.
  - Otherwise: extract and register the result, next state RESP.
- **RD1:** capture word1, extract, register the result, next state RESP.
- **Extraction:**
  - Form the 64-bit value {word1, word0}; word1 = 0 when there was no second read.
  - Shift right by offset*8.
  - Take bits [7:0], [15:0] or [31:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the value unchanged.
- **RESP:**
  - `resp_valid`=1.
  - `resp_data` and `resp_err` are held stable until `resp_valid && resp_ready`.
  - Then next state IDLE.
- `mem_en`=0 in every state and cycle not listed above.

## Timing
- **Reset (`rst_n` low):**
  - State goes to IDLE immediately.
  - `resp_valid`=0, `resp_data`=0, `resp_err`=0, `mem_en`=0, `mem_addr`=0, `req_ready`=0.
- **Reset released:** `req_ready`=1 from the first cycle with `rst_n` high.
- **Latency (accept = cycle 0):**
  - Aligned load: `resp_valid` in cycle 2.
  - Split load: `resp_valid` in cycle 3.
  - Error or non-load: `resp_valid` in cycle 1.
- **Throughput:** one request in flight. The earliest next accept is the cycle after the response handshake; responses and requests never overlap.
- **Consumer holding off:** `resp_ready` low in RESP stalls indefinitely with outputs frozen and no `mem_en`.
- **`resp_ready` high the same cycle `resp_valid` rises:** completes in that cycle.
- **Reset mid-operation (RD0/RD1/RESP):**
  - The in-flight load is dropped, and no `resp_valid` is ever produced for it.
  - Late `mem_rdata` is ignored.
- `resp_data`/`resp_err` are registered outputs. `mem_en`/`mem_addr` are combinational from state and latched/request fields.

## Test plan
Memory contents: 0x100 = 0x8899AABB, 0x104 = 0x11223344.
- LB @0x103 → `resp_data`=0xFFFFFF88; LBU @0x103 → 0x00000088. Each has one `mem_en` pulse with `mem_addr`=0x100, and `resp_valid` in cycle 2.
- LH @0x102 → 0xFFFF8899; LHU @0x101 → 0x000099AA; LW @0x100 → 0x8899AABB. All have `resp_err`=0.
- LW @0x102 → two `mem_en` pulses (0x100 in cycle 0, 0x104 in cycle 1), `resp_data`=0x33448899, `resp_valid` in cycle 3.
- LH @0x103 → 0x00004488. With `ALLOW_SPLIT`=0 → `resp_data`=0, `resp_err`=1, single read.
- LW @0xFFFFFFFE → second `mem_addr`=0x00000000. Store-opcode inst → no `mem_en`, `resp_valid` in cycle 1, `resp_err`=1, `resp_data`=0.
- Hold `resp_ready` low for 5 cycles → `resp_data` stable, `req_ready`=0, `mem_en`=0 throughout. Assert `rst_n` low during RD1 → `resp_valid` never rises, and `req_ready`=1 the cycle after release.
